// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the receiver state encoding, timing defaults and small timing helpers.
package uart_program_loader_pkg;

    localparam int UART_CLK_FREQ_DEFAULT  = 50_000_000;
    localparam int UART_BAUD_RATE_DEFAULT = 115_200;
    localparam int UART_CLKS_PER_BIT      = UART_CLK_FREQ_DEFAULT / UART_BAUD_RATE_DEFAULT;
    localparam int UART_CLKS_PER_BIT_MIN  = 4;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Last counter value of the half-bit wait that lands the start-bit sample mid-bit.
    function automatic int half_bit_last(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

    function automatic int full_bit_last(input int clks_per_bit);
        return clks_per_bit - 1;
    endfunction

endpackage

// File: rtl/uart_program_loader_sync_2ff.sv
// Purpose: two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: 2 clocks from input change to q.
// Backpressure: none; a free-running level path.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Purpose: 8N1 UART receiver that hands each good byte to the instruction memory load port.
// Latency: valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the start-bit edge.
// Backpressure: none; one-cycle valid pulses, spaced at least one frame apart, gated by load_enable.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ     = UART_CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE    = UART_BAUD_RATE_DEFAULT,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic        uart_rx,
    input  logic        load_enable,
    output logic [7:0]  inst_to_CPU,
    output logic        inst_to_CPU_valid,
    output logic        rx_busy,
    output logic        frame_error,
    output logic [31:0] byte_count
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(full_bit_last(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_s;

    // Idle line is high, so the synchroniser resets to 1 to avoid a false start bit.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (SYS_reset),
        .d   (uart_rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            state             <= RX_IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shreg             <= '0;
            inst_to_CPU       <= 8'h00;
            inst_to_CPU_valid <= 1'b0;
            frame_error       <= 1'b0;
            byte_count        <= '0;
        end else begin
            inst_to_CPU_valid <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is already gone by mid-bit was noise.
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            inst_to_CPU       <= shreg;
                            inst_to_CPU_valid <= load_enable;
                            byte_count        <= byte_count + {31'd0, load_enable};
                            state             <= RX_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_WAIT_IDLE: begin
                    cnt <= '0;
                    // Hold off until the line releases so a break cannot re-trigger.
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a byte scoreboard fed by the frame driver.
// A negedge monitor pops expected bytes on each valid pulse and tracks pulse spacing and busy time.
module tb_uart_program_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        load_enable = 1'b1;
    logic [7:0]  inst_to_CPU;
    logic        inst_to_CPU_valid;
    logic        rx_busy;
    logic        frame_error;
    logic [31:0] byte_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    int         cycle = 0;
    int         pulse_cnt = 0;
    int         busy_cnt = 0;
    int         last_pulse = -1;
    int         min_gap = 1_000_000;
    logic       prev_valid = 1'b0;

    uart_program_loader #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk               (clk),
        .SYS_reset         (SYS_reset),
        .uart_rx           (uart_rx),
        .load_enable       (load_enable),
        .inst_to_CPU       (inst_to_CPU),
        .inst_to_CPU_valid (inst_to_CPU_valid),
        .rx_busy           (rx_busy),
        .frame_error       (frame_error),
        .byte_count        (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (rx_busy) busy_cnt++;
        if (inst_to_CPU_valid) begin
            pulse_cnt++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("sb_byte", {24'd0, inst_to_CPU}, {24'd0, exp_q.pop_front()});
            if (last_pulse >= 0 && cycle - last_pulse < min_gap) min_gap = cycle - last_pulse;
            last_pulse = cycle;
        end
        prev_valid = inst_to_CPU_valid;
    end

    task automatic do_reset();
        @(posedge clk);
        SYS_reset = 1'b1;
        repeat (3) @(posedge clk);
        SYS_reset = 1'b0;
        @(posedge clk);
        pulse_cnt  = 0;
        busy_cnt   = 0;
        last_pulse = -1;
        min_gap    = 1_000_000;
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    // rst_bit >= 0 pulses SYS_reset at the middle of that data bit and checks the reset outputs.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
        if (stop && load_enable && rst_bit < 0) exp_q.push_back(b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                uart_rx = b[i];
                repeat (CPB / 2) @(posedge clk);
                SYS_reset = 1'b1;
                @(posedge clk);
                #1;
                check("midrst_inst", {24'd0, inst_to_CPU}, 32'd0);
                check("midrst_valid", {31'd0, inst_to_CPU_valid}, 32'd0);
                check("midrst_busy", {31'd0, rx_busy}, 32'd0);
                check("midrst_ferr", {31'd0, frame_error}, 32'd0);
                check("midrst_count", byte_count, 32'd0);
                SYS_reset = 1'b0;
                repeat (CPB / 2 - 1) @(posedge clk);
            end else begin
                bit_time(b[i]);
            end
        end
        bit_time(stop);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(posedge clk);
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", {24'd0, inst_to_CPU}, 32'd0);
        check("rst_valid", {31'd0, inst_to_CPU_valid}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_count", byte_count, 32'd0);
        SYS_reset = 1'b0;
        do_reset();

        // Single good byte
        send_frame(8'hA5, 1'b1, -1);
        bit_time(1'b1);
        drain("a5_drain");
        check("a5_pulses", pulse_cnt, 32'd1);
        check("a5_inst", {24'd0, inst_to_CPU}, 32'hA5);
        check("a5_count", byte_count, 32'd1);
        check("a5_ferr", {31'd0, frame_error}, 32'd0);

        // Back-to-back frames, no idle gap
        do_reset();
        send_frame(8'h13, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h6F, 1'b1, -1);
        bit_time(1'b1);
        drain("b2b_drain");
        check("b2b_pulses", pulse_cnt, 32'd4);
        check("b2b_count", byte_count, 32'd4);
        check("b2b_gap_ge_160", {31'd0, min_gap >= 10 * CPB}, 32'd1);

        // Short glitch shorter than half a bit
        do_reset();
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("glitch_pulses", pulse_cnt, 32'd0);
        check("glitch_ferr", {31'd0, frame_error}, 32'd0);
        check("glitch_busy_now", {31'd0, rx_busy}, 32'd0);
        check("glitch_busy_cycles", busy_cnt, CPB / 2);

        // Framing error then recovery
        do_reset();
        send_frame(8'h3C, 1'b0, -1);
        bit_time(1'b0);
        #1;
        check("ferr_set", {31'd0, frame_error}, 32'd1);
        check("ferr_inst_kept", {24'd0, inst_to_CPU}, 32'd0);
        bit_time(1'b1);
        bit_time(1'b1);
        send_frame(8'h81, 1'b1, -1);
        bit_time(1'b1);
        drain("ferr_drain");
        check("ferr_sticky", {31'd0, frame_error}, 32'd1);
        check("ferr_pulses", pulse_cnt, 32'd1);
        check("ferr_inst", {24'd0, inst_to_CPU}, 32'h81);
        check("ferr_count", byte_count, 32'd1);

        // load_enable gating
        do_reset();
        load_enable = 1'b0;
        send_frame(8'h55, 1'b1, -1);
        bit_time(1'b1);
        check("gate_pulses", pulse_cnt, 32'd0);
        check("gate_count", byte_count, 32'd0);
        check("gate_inst", {24'd0, inst_to_CPU}, 32'h55);
        load_enable = 1'b1;
        send_frame(8'h77, 1'b1, -1);
        bit_time(1'b1);
        drain("gate_drain");
        check("ungate_pulses", pulse_cnt, 32'd1);
        check("ungate_count", byte_count, 32'd1);

        // Reset mid-frame, then a clean frame
        pulse_cnt = 0;
        send_frame(8'hF0, 1'b1, 4);
        bit_time(1'b1);
        check("postrst_pulses", pulse_cnt, 32'd0);
        send_frame(8'h0F, 1'b1, -1);
        bit_time(1'b1);
        drain("postrst_drain");
        check("postrst_inst", {24'd0, inst_to_CPU}, 32'h0F);
        check("postrst_count", byte_count, 32'd1);
        check("postrst_pulses2", pulse_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
